// File: rtl/io_reg_pkg.sv
// Shared types and constants for the IO_REG tile configuration sequencer.
// Packet layout: isel, fixhold, osel lo, osel hi, {dsel, rsvd, osel top}, xor checksum.
package io_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    CHECK,
    APPLY,
    FLUSH
  } state_t;

  localparam int B_ISEL    = 0;
  localparam int B_FIXHOLD = 1;
  localparam int B_OSEL_LO = 2;
  localparam int B_OSEL_HI = 3;
  localparam int B_MISC    = 4;
  localparam int B_CSUM    = 5;
  localparam int PKT_BYTES = 6;
  localparam int CNT_W     = 3;

  localparam int ISEL_W    = 8;
  localparam int OSEL_W    = 18;
  localparam int DSEL_W    = 4;
  localparam int FIXHOLD_W = 8;

  localparam logic [ISEL_W-1:0] ISEL_RST = 8'hFF;
  localparam logic [OSEL_W-1:0] OSEL_RST = 18'h3FFFF;

  function automatic logic [OSEL_W-1:0] osel_join(input logic [7:0] lo,
                                                  input logic [7:0] hi,
                                                  input logic [1:0] top);
    return {top, hi, lo};
  endfunction

endpackage

// File: rtl/io_reg_cfg_shadow.sv
// Six-byte packet shadow with running XOR checksum and reserved-bit check.
// Fields are presented unpacked; o_pass is valid once the checksum byte is stored.
module io_reg_cfg_shadow
  import io_reg_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [CNT_W-1:0]     i_idx,
  input  logic [7:0]           i_data,
  output logic [ISEL_W-1:0]    o_isel,
  output logic [FIXHOLD_W-1:0] o_fixhold,
  output logic [OSEL_W-1:0]    o_osel,
  output logic [DSEL_W-1:0]    o_dsel,
  output logic                 o_pass
);

  logic [7:0] r_mem [PKT_BYTES];
  logic [7:0] r_csum;
  logic [1:0] w_rsvd;
  logic       w_csum_ok;

  // Byte 0 restarts the running XOR so a previous partial packet cannot bias it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        r_mem[i] <= '0;
      end
      r_csum <= '0;
    end else if (i_wr) begin
      r_mem[i_idx] <= i_data;
      r_csum       <= (i_idx == CNT_W'(B_ISEL)) ? i_data : (r_csum ^ i_data);
    end
  end

  assign o_isel    = r_mem[B_ISEL];
  assign o_fixhold = r_mem[B_FIXHOLD];
  assign o_osel    = osel_join(r_mem[B_OSEL_LO], r_mem[B_OSEL_HI], r_mem[B_MISC][1:0]);
  assign o_dsel    = r_mem[B_MISC][7:4];
  assign w_rsvd    = r_mem[B_MISC][3:2];
  assign w_csum_ok = (r_csum == 8'h00);
  assign o_pass    = (w_rsvd == 2'b00) && (!CHECK_EN || w_csum_ok);

endmodule

// File: rtl/io_reg_cfg_ctrl.sv
// Config sequencer for one IO_REG tile: receives a checked 6-byte packet,
// applies all selects on one edge, then holds the tile in reset to flush stale data.
module io_reg_cfg_ctrl
  import io_reg_pkg::*;
#(
  parameter int FLUSH_CYCLES = 4,
  parameter bit CHECK_EN     = 1'b1
) (
  input  logic                 IQC,
  input  logic                 QRT,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [7:0]           cfg_data,
  input  logic                 cfg_last,
  output logic [ISEL_W-1:0]    isel,
  output logic [OSEL_W-1:0]    osel,
  output logic [DSEL_W-1:0]    dsel,
  output logic [FIXHOLD_W-1:0] fixhold,
  output logic                 reg_rst,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic [3:0]             r_flush, w_flush_next;
  logic                   r_done, w_done_next;
  logic                   r_err, w_err_next;
  logic [ISEL_W-1:0]      r_isel;
  logic [OSEL_W-1:0]      r_osel;
  logic [DSEL_W-1:0]      r_dsel;
  logic [FIXHOLD_W-1:0]   r_fixhold;

  logic                   w_ready;
  logic                   w_accept;
  logic                   w_wr;
  logic [CNT_W-1:0]       w_wr_idx;
  logic                   w_apply;
  logic                   w_pass;
  logic [ISEL_W-1:0]      w_sh_isel;
  logic [OSEL_W-1:0]      w_sh_osel;
  logic [DSEL_W-1:0]      w_sh_dsel;
  logic [FIXHOLD_W-1:0]   w_sh_fixhold;

  io_reg_cfg_shadow #(
    .CHECK_EN (CHECK_EN)
  ) u_shadow (
    .i_clk     (IQC),
    .i_rst     (QRT),
    .i_wr      (w_wr),
    .i_idx     (w_wr_idx),
    .i_data    (cfg_data),
    .o_isel    (w_sh_isel),
    .o_fixhold (w_sh_fixhold),
    .o_osel    (w_sh_osel),
    .o_dsel    (w_sh_dsel),
    .o_pass    (w_pass)
  );

  // Ready is a pure function of state so the handshake has no comb loop.
  assign w_ready   = (r_state == IDLE) || (r_state == LOAD) || (r_state == DRAIN);
  assign cfg_ready = w_ready & ~QRT;
  assign w_accept  = cfg_valid & cfg_ready;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_flush_next = r_flush;
    w_done_next  = 1'b0;
    w_err_next   = 1'b0;
    w_wr         = 1'b0;
    w_wr_idx     = r_cnt;
    w_apply      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_wr     = 1'b1;
          w_wr_idx = CNT_W'(B_ISEL);
          if (cfg_last) begin
            w_err_next = 1'b1;
          end else begin
            w_cnt_next   = CNT_W'(1);
            w_state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_wr = 1'b1;
          if (r_cnt == CNT_W'(B_CSUM)) begin
            w_cnt_next = '0;
            if (cfg_last) begin
              w_state_next = CHECK;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = DRAIN;
            end
          end else if (cfg_last) begin
            w_err_next   = 1'b1;
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        // Overlong packet already flagged; swallow the rest silently.
        if (w_accept && cfg_last) begin
          w_state_next = IDLE;
        end
      end
      CHECK: begin
        if (w_pass) begin
          w_state_next = APPLY;
        end else begin
          w_err_next   = 1'b1;
          w_state_next = IDLE;
        end
      end
      APPLY: begin
        w_apply      = 1'b1;
        w_flush_next = FLUSH_INIT;
        w_state_next = FLUSH;
      end
      FLUSH: begin
        // Leaving on the last count makes done coincide with reg_rst falling.
        if (r_flush <= 4'd1) begin
          w_flush_next = '0;
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_flush_next = r_flush - 4'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_flush_next = '0;
      end
    endcase
  end

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_flush   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_isel    <= ISEL_RST;
      r_osel    <= OSEL_RST;
      r_dsel    <= '0;
      r_fixhold <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_flush <= w_flush_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      if (w_apply) begin
        r_isel    <= w_sh_isel;
        r_osel    <= w_sh_osel;
        r_dsel    <= w_sh_dsel;
        r_fixhold <= w_sh_fixhold;
      end
    end
  end

  assign isel    = r_isel;
  assign osel    = r_osel;
  assign dsel    = r_dsel;
  assign fixhold = r_fixhold;
  assign reg_rst = QRT | (r_flush != 4'd0);
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign err     = r_err;

endmodule
